// File: rtl/lmk_uwire_master.sv
// lmk_uwire_master
// MicroWire write/readback master for LMK-family clock chips that share one
// CLKUWIRE/DATAUWIRE bus and have one LEUWIRE each. One request shifts a
// DW-bit word out MSB first, captures the readback line during the same
// shift, and then pulses the latch-enable of the selected chip.
module lmk_uwire_master #(
  parameter int DW     = 32,
  parameter int NCS    = 2,
  parameter int CSW    = 3,
  parameter int DIV    = 4,
  parameter int LE_CYC = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [DW-1:0]  i_wdata,
  input  logic [CSW-1:0] i_cs_sel,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err,
  output logic [DW-1:0]  o_rdata,
  output logic           o_uwire_clk,
  output logic           o_uwire_data,
  output logic [NCS-1:0] o_uwire_le,
  input  logic           i_uwire_din
);

  // One counter serves every timed phase, so it must hold the longer of the
  // half-period and the latch-enable width.
  localparam int CNT_MAX = (DIV > LE_CYC) ? DIV : LE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(DW);
  localparam logic [CSW:0] NCS_LIM = (CSW+1)'(NCS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_LATCH,
    S_GAP
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [BW-1:0]  r_bit;
  logic [BW-1:0]  w_bit_nxt;
  logic [DW-1:0]  r_shift;
  logic [DW-1:0]  w_shift_nxt;
  logic [DW-1:0]  r_cap;
  logic [DW-1:0]  w_cap_nxt;
  logic [CSW-1:0] r_chan;
  logic [CSW-1:0] w_chan_nxt;

  logic           r_din_s1;
  logic           r_din_s2;

  logic           r_busy;
  logic           r_done;
  logic           r_err;
  logic [DW-1:0]  r_rdata;
  logic           r_uclk;
  logic           r_udata;
  logic [NCS-1:0] r_le;

  logic           w_busy_nxt;
  logic           w_done_nxt;
  logic           w_err_nxt;
  logic [DW-1:0]  w_rdata_nxt;
  logic           w_uclk_nxt;
  logic           w_udata_nxt;
  logic [NCS-1:0] w_le_nxt;

  logic           w_div_last;
  logic           w_le_last;
  logic           w_bit_last;
  logic           w_cs_ok;
  logic [NCS-1:0] w_le_onehot;

  assign w_div_last  = (r_cnt == CW'(DIV - 1));
  assign w_le_last   = (r_cnt == CW'(LE_CYC - 1));
  assign w_bit_last  = (r_bit == BW'(DW - 1));
  assign w_cs_ok     = ({1'b0, i_cs_sel} < NCS_LIM);
  assign w_le_onehot = NCS'(1) << r_chan;

  // Bring the asynchronous readback pin into the clk domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_din_s1 <= 1'b0;
      r_din_s2 <= 1'b0;
    end else begin
      r_din_s1 <= i_uwire_din;
      r_din_s2 <= r_din_s1;
    end
  end

  // FSM state, phase counter, bit index and shift/capture registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_cap   <= '0;
      r_chan  <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_cap   <= w_cap_nxt;
      r_chan  <= w_chan_nxt;
    end
  end

  // Next state plus the next value of every pin/status register; pin changes
  // are tied to phase transitions so data only moves with a falling CLKUWIRE.
  always_comb begin
    w_next_state = r_state;
    w_cnt_nxt    = r_cnt + CW'(1);
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_cap_nxt    = r_cap;
    w_chan_nxt   = r_chan;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_rdata_nxt  = r_rdata;
    w_uclk_nxt   = r_uclk;
    w_udata_nxt  = r_udata;
    w_le_nxt     = r_le;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt   = '0;
        w_uclk_nxt  = 1'b0;
        w_udata_nxt = 1'b0;
        w_le_nxt    = '0;
        if (i_start) begin
          if (w_cs_ok) begin
            w_next_state = S_SETUP;
            w_shift_nxt  = i_wdata;
            w_chan_nxt   = i_cs_sel;
            w_bit_nxt    = '0;
            w_udata_nxt  = i_wdata[DW-1];
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      S_SETUP: begin
        if (w_div_last) begin
          w_next_state = S_HIGH;
          w_cnt_nxt    = '0;
          w_uclk_nxt   = 1'b1;
          w_cap_nxt    = {r_cap[DW-2:0], r_din_s2};
        end
      end

      S_HIGH: begin
        if (w_div_last) begin
          w_next_state = S_LOW;
          w_cnt_nxt    = '0;
          w_uclk_nxt   = 1'b0;
          if (!w_bit_last) begin
            w_shift_nxt = {r_shift[DW-2:0], 1'b0};
            w_udata_nxt = r_shift[DW-2];
          end
        end
      end

      S_LOW: begin
        if (w_div_last) begin
          w_cnt_nxt = '0;
          if (w_bit_last) begin
            w_next_state = S_LATCH;
            w_le_nxt     = w_le_onehot;
          end else begin
            w_next_state = S_HIGH;
            w_bit_nxt    = r_bit + BW'(1);
            w_uclk_nxt   = 1'b1;
            w_cap_nxt    = {r_cap[DW-2:0], r_din_s2};
          end
        end
      end

      S_LATCH: begin
        if (w_le_last) begin
          w_next_state = S_GAP;
          w_cnt_nxt    = '0;
          w_le_nxt     = '0;
        end
      end

      S_GAP: begin
        if (w_div_last) begin
          w_next_state = S_IDLE;
          w_cnt_nxt    = '0;
          w_done_nxt   = 1'b1;
          w_rdata_nxt  = r_cap;
          w_udata_nxt  = 1'b0;
        end
      end

      default: begin
        w_next_state = S_IDLE;
        w_cnt_nxt    = '0;
      end
    endcase
  end

  assign w_busy_nxt = (w_next_state != S_IDLE);

  // Output registers, so every pin and status flag comes straight off a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_uclk  <= 1'b0;
      r_udata <= 1'b0;
      r_le    <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
      r_uclk  <= w_uclk_nxt;
      r_udata <= w_udata_nxt;
      r_le    <= w_le_nxt;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_rdata      = r_rdata;
  assign o_uwire_clk  = r_uclk;
  assign o_uwire_data = r_udata;
  assign o_uwire_le   = r_le;

endmodule

// File: tb/tb_lmk_uwire_master.sv
// tb_lmk_uwire_master
// Random and directed stimulus for lmk_uwire_master, checked every cycle
// against a timeline model of one transaction, plus a small DIV=1 instance.
module tb_lmk_uwire_master;

  localparam int DW     = 32;
  localparam int NCS    = 2;
  localparam int CSW    = 3;
  localparam int DIV    = 4;
  localparam int LE_CYC = 4;
  localparam int TOTAL  = DIV + 2*DIV*DW + LE_CYC + DIV;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic [DW-1:0]  wdata = '0;
  logic [CSW-1:0] csSel = '0;
  logic           din = 1'b0;
  logic           busy, done, err, uClk, uData;
  logic [DW-1:0]  rdata;
  logic [NCS-1:0] uLe;

  logic           start2 = 1'b0;
  logic [23:0]    wdata2 = '0;
  logic [0:0]     csSel2 = '0;
  logic           din2 = 1'b0;
  logic           busy2, done2, err2, uClk2, uData2;
  logic [23:0]    rdata2;
  logic [0:0]     uLe2;

  lmk_uwire_master #(.DW(DW), .NCS(NCS), .CSW(CSW), .DIV(DIV), .LE_CYC(LE_CYC)) u_dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_wdata(wdata), .i_cs_sel(csSel),
    .o_busy(busy), .o_done(done), .o_err(err), .o_rdata(rdata),
    .o_uwire_clk(uClk), .o_uwire_data(uData), .o_uwire_le(uLe), .i_uwire_din(din)
  );

  lmk_uwire_master #(.DW(24), .NCS(1), .CSW(1), .DIV(1), .LE_CYC(1)) u_dut2 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start2), .i_wdata(wdata2), .i_cs_sel(csSel2),
    .o_busy(busy2), .o_done(done2), .o_err(err2), .o_rdata(rdata2),
    .o_uwire_clk(uClk2), .o_uwire_data(uData2), .o_uwire_le(uLe2), .i_uwire_din(din2)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Model state: where the current transaction is on its timeline
  bit            mBusy = 0;
  int            mT = 0;
  logic [DW-1:0] mWord = '0;
  logic [DW-1:0] mRdWord = '0;
  logic [DW-1:0] mRdata = '0;
  int            mChan = 0;
  bit            mDone = 0;
  bit            mErr = 0;
  logic [DW-1:0] nextRdWord = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Index (0 = MSB) of the word bit that should be on DATAUWIRE at offset t
  function automatic int lineBit(input int t);
    int u;
    int b;
    if (t <= DIV) return 0;
    u = t - DIV - 1;
    if (u >= 2*DIV*DW) return DW - 1;
    b = u / (2*DIV);
    if ((u % (2*DIV)) < DIV) return b;
    return (b + 1 > DW - 1) ? DW - 1 : b + 1;
  endfunction

  // {uwire_clk, uwire_data, uwire_le} expected at busy offset t (1..TOTAL)
  function automatic logic [NCS+1:0] expectedPins(input int t, input logic [DW-1:0] w, input int chan);
    logic c;
    logic d;
    logic [NCS-1:0] le;
    int u;
    int v;
    c  = 1'b0;
    le = '0;
    d  = w[DW-1-lineBit(t)];
    if (t > DIV) begin
      u = t - DIV - 1;
      if (u < 2*DIV*DW) begin
        c = ((u % (2*DIV)) < DIV);
      end else begin
        v = u - 2*DIV*DW;
        if (v < LE_CYC) le[chan] = 1'b1;
      end
    end
    return {c, d, le};
  endfunction

  // Advance the model on each rising clock from the bench-driven inputs
  always @(posedge clk) begin
    if (!rstN) begin
      mBusy = 0; mT = 0; mDone = 0; mErr = 0; mRdata = '0;
    end else begin
      mDone = 0;
      mErr  = 0;
      if (!mBusy) begin
        if (start) begin
          if (int'(csSel) < NCS) begin
            mBusy = 1; mT = 1; mWord = wdata; mChan = int'(csSel); mRdWord = nextRdWord;
          end else begin
            mErr = 1;
          end
        end
      end else begin
        mT++;
        if (mT > TOTAL) begin
          mBusy = 0; mDone = 1; mRdata = mRdWord;
        end
      end
    end
  end

  // Chip readback: present the bit that belongs to the current CLKUWIRE period
  always @(negedge clk) begin
    if (mBusy) din = mRdWord[DW-1-lineBit(mT)];
    else       din = 1'($urandom);
  end

  // Compare every cycle against the model
  always @(posedge clk) begin
    logic [NCS+1:0] expPins;
    #1;
    expPins = mBusy ? expectedPins(mT, mWord, mChan) : '0;
    checkOutput("pins", {uClk, uData, uLe}, expPins);
    checkOutput("busy", busy, mBusy);
    checkOutput("done", done, mDone);
    checkOutput("err", err, mErr);
    checkOutput("rdata", rdata, mRdata);
  end

  // Observed statistics for the directed scenarios
  int busyCycles, rises, leCycles, leRises, doneCount;
  logic [DW-1:0] bitsSeen;
  logic [NCS-1:0] leOr, prevLe;
  logic prevClk;
  int busy2Cycles, rises2, le2Cycles, done2Count, run2, badWidth2;
  logic [23:0] bits2Seen;
  logic prevClk2;

  task automatic clearStats();
    busyCycles = 0; rises = 0; leCycles = 0; leRises = 0; doneCount = 0;
    bitsSeen = '0; leOr = '0; prevLe = '0; prevClk = 1'b0;
    busy2Cycles = 0; rises2 = 0; le2Cycles = 0; done2Count = 0; run2 = 0; badWidth2 = 0;
    bits2Seen = '0; prevClk2 = 1'b0;
  endtask

  // Gather pin activity for both instances
  always @(posedge clk) begin
    #1;
    if (busy) busyCycles++;
    if (uClk && !prevClk) begin bitsSeen = {bitsSeen[DW-2:0], uData}; rises++; end
    prevClk = uClk;
    if (uLe != '0) begin leCycles++; leOr = leOr | uLe; end
    if (uLe != '0 && prevLe == '0) leRises++;
    prevLe = uLe;
    if (done) doneCount++;
    if (busy2) busy2Cycles++;
    if (uClk2 && !prevClk2) begin bits2Seen = {bits2Seen[22:0], uData2}; rises2++; end
    if (uClk2) run2++;
    else if (run2 > 0) begin if (run2 != 1) badWidth2++; run2 = 0; end
    prevClk2 = uClk2;
    if (uLe2 != '0) le2Cycles++;
    if (done2) done2Count++;
  end

  task automatic applyStimulus(input bit s, input logic [DW-1:0] w, input logic [CSW-1:0] cs, input logic [DW-1:0] rd);
    @(negedge clk);
    start = s; wdata = w; csSel = cs; nextRdWord = rd;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic waitDone(input int bound, input string name);
    int n;
    n = 0;
    while (!done && n < bound) begin stepCycle(); n++; end
    checkOutput(name, done, 1'b1);
  endtask

  initial begin
    rstN = 1'b1;
    #1 rstN = 1'b0;
    clearStats();
    repeat (3) stepCycle();
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset err", err, 1'b0);
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset pins", {uClk, uData, uLe}, 4'b0000);
    @(negedge clk) rstN = 1'b1;
    repeat (2) stepCycle();

    // Single write with readback on channel 1
    clearStats();
    applyStimulus(1, 32'hA5C3_0F1E, 3'd1, 32'h1234_5678);
    applyStimulus(0, 32'h0, 3'd0, 32'h0);
    waitDone(400, "write1 done timeout");
    checkOutput("write1 busy cycles", busyCycles, 268);
    checkOutput("write1 rising edges", rises, 32);
    checkOutput("write1 bits", bitsSeen, 32'hA5C3_0F1E);
    checkOutput("write1 le cycles", leCycles, 4);
    checkOutput("write1 le value", leOr, 2'b10);
    checkOutput("write1 rdata", rdata, 32'h1234_5678);
    repeat (4) stepCycle();
    checkOutput("write1 done count", doneCount, 1);

    // Rejected channel index
    clearStats();
    applyStimulus(1, 32'hFFFF_FFFF, 3'd3, 32'h0);
    stepCycle();
    checkOutput("reject err", err, 1'b1);
    checkOutput("reject busy", busy, 1'b0);
    applyStimulus(0, 32'h0, 3'd0, 32'h0);
    stepCycle();
    checkOutput("reject err clear", err, 1'b0);
    repeat (4) stepCycle();
    checkOutput("reject pin activity", rises + leCycles + busyCycles, 0);

    // Back-to-back with start held high
    clearStats();
    applyStimulus(1, 32'h5A5A_C3C3, 3'd0, 32'h8765_4321);
    waitDone(400, "b2b first done timeout");
    stepCycle();
    checkOutput("b2b second accepted", busy, 1'b1);
    applyStimulus(0, 32'h0, 3'd0, 32'h0);
    waitDone(400, "b2b second done timeout");
    repeat (5) stepCycle();
    checkOutput("b2b le pulses", leRises, 2);
    checkOutput("b2b done count", doneCount, 2);
    checkOutput("b2b rising edges", rises, 64);

    // Reset in the middle of a word
    clearStats();
    applyStimulus(1, 32'hDEAD_BEEF, 3'd1, 32'h0F0F_0F0F);
    applyStimulus(0, 32'h0, 3'd0, 32'h0);
    for (int n = 0; n < 200 && rises < 11; n++) stepCycle();
    checkOutput("midreset reached bit 10", rises, 11);
    @(negedge clk) rstN = 1'b0;
    #1;
    checkOutput("midreset outputs", {busy, done, err, uClk, uData, uLe}, 7'b0);
    checkOutput("midreset rdata", rdata, 32'h0);
    checkOutput("midreset no le", leRises, 0);
    repeat (2) stepCycle();
    @(negedge clk) rstN = 1'b1;
    clearStats();
    applyStimulus(1, 32'h3C5A_9618, 3'd0, 32'hCAFE_F00D);
    applyStimulus(0, 32'h0, 3'd0, 32'h0);
    waitDone(400, "postreset done timeout");
    checkOutput("postreset bits", bitsSeen, 32'h3C5A_9618);
    checkOutput("postreset rdata", rdata, 32'hCAFE_F00D);
    checkOutput("postreset le value", leOr, 2'b01);
    checkOutput("postreset busy cycles", busyCycles, 268);

    // Random traffic, including ignored and rejected requests
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      wdata = $urandom;
      csSel = ($urandom_range(0, 4) == 0) ? CSW'($urandom_range(2, 7)) : CSW'($urandom_range(0, 1));
      nextRdWord = $urandom;
      if (!rstN) rstN = 1'b1;
      else if ($urandom_range(0, 1499) == 0) rstN = 1'b0;
    end
    @(negedge clk) begin start = 1'b0; rstN = 1'b1; end
    for (int n = 0; n < 400 && busy; n++) stepCycle();
    checkOutput("random drained", busy, 1'b0);

    // Fastest divider, 24-bit word, single channel
    clearStats();
    @(negedge clk) begin start2 = 1'b1; wdata2 = 24'hFF_FFFF; end
    @(negedge clk) start2 = 1'b0;
    for (int n = 0; n < 100 && !done2; n++) stepCycle();
    checkOutput("div1 done", done2, 1'b1);
    checkOutput("div1 busy cycles", busy2Cycles, 51);
    checkOutput("div1 rising edges", rises2, 24);
    checkOutput("div1 bits", bits2Seen, 24'hFF_FFFF);
    checkOutput("div1 high width", badWidth2, 0);
    checkOutput("div1 le cycles", le2Cycles, 1);
    checkOutput("div1 done count", done2Count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
